sf_camera_reader: RTL
=====================

SF_CAMERA_READER -- requirements
Module: sf_camera_reader

Interface
REQ-001 SHALL have exactly one clock and one reset: rst is asynchronous and active-low (asserted when 0).
REQ-002 Ports, in order:
  clk  in  1  system clock, at least 4x camera pixel clock
  rst  in  1  asynchronous active-low reset
  i_enable  in  1  capture enable, driven by the controller's reader enable
  i_pclk  in  1  camera pixel clock, sampled as data
  i_vsync  in  1  camera frame sync, high during vertical blanking
  i_href  in  1  camera line valid, high while bytes are valid
  i_pix_data  in  8  camera byte bus
  i_wr_full  in  1  downstream pixel FIFO full
  o_wr_data  out  16  RGB565 pixel, first byte in [15:8]
  o_wr_stb  out  1  one-cycle pixel write strobe
  o_frame_done  out  1  one-cycle end-of-frame pulse
  o_row_count  out  16  rows completed in the current or last frame
  o_pixel_count  out  16  pixels in the last completed row
  o_overflow  out  1  sticky flag: a pixel was dropped on full
  o_busy  out  1  high in any state other than IDLE

Function
REQ-003 i_pclk, i_vsync and i_href SHALL each pass through a 2-flop synchronizer; i_pix_data SHALL be delayed 2 clk to stay aligned with them.
REQ-004 A pclk event SHALL be a synchronized 0->1 transition, detected against a third register stage.
REQ-005 FSM states SHALL be IDLE, WAIT_FRAME, WAIT_LINE, CAPTURE and DONE.
REQ-006 IDLE->WAIT_FRAME on i_enable=1.
REQ-007 WAIT_FRAME->WAIT_LINE on a synchronized vsync 1->0 edge; this edge SHALL clear o_row_count, o_pixel_count and o_overflow.
REQ-008 WAIT_LINE->CAPTURE on a pclk event with href=1, and that byte SHALL be captured as the high byte.
REQ-009 In CAPTURE, bytes SHALL alternate high/low on each pclk event with href=1; each low byte completes one pixel.
REQ-010 For each completed pixel with i_wr_full=0, o_wr_stb SHALL be 1 for exactly one cycle, 3 clk after the pixel's pin-level pclk rising edge, with o_wr_data valid in the same cycle.
REQ-011 A pixel completed while i_wr_full=1 SHALL be dropped (no strobe) and SHALL set o_overflow; it still counts toward the row pixel total.
REQ-012 CAPTURE->WAIT_LINE on synchronized href 1->0:
  - row counter increments;
  - o_pixel_count latches the row's pixel total;
  - an odd trailing high byte is discarded.
REQ-013 From WAIT_LINE or CAPTURE, a synchronized vsync 0->1 edge SHALL go to DONE; a partial row at that edge SHALL be counted as a row.
REQ-014 DONE SHALL pulse o_frame_done for one cycle, then go to WAIT_FRAME if i_enable=1, else to IDLE.
REQ-015 i_enable=0 in any state other than DONE SHALL go to IDLE on the next clk, discarding any partial pixel and producing no o_frame_done; counters and o_overflow SHALL hold their values.
REQ-016 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-017 If href falls and vsync rises in the same cycle, the row completion (REQ-012) SHALL be applied first, followed by the DONE transition in that same cycle.
REQ-018 Outputs SHALL be registered; o_busy SHALL be decoded from the FSM state.

Reset
REQ-019 While rst=0, all outputs, counters and synchronizer flops SHALL be 0 and the FSM SHALL be in IDLE; the block leaves reset on the first clk edge after rst returns to 1.
REQ-020 Reset asserted mid-frame SHALL take effect immediately, with no o_wr_stb or o_frame_done emitted.

Configuration
REQ-021 When SF_CAMERA_TEST_PATTERN_EN is defined:
  - captured camera bytes are replaced by a generated pattern, where pixel = {column[7:0], row[7:0]} using the current pixel index and row count;
  - all timing still follows pclk, href and vsync.
REQ-022 When SF_CAMERA_TEST_PATTERN_EN is undefined, the block SHALL contain no pattern logic and the camera bytes are passed through.

Verification
REQ-023 Basic frame: i_enable=1, frame of 2 rows x 4 pixels, bytes 0x12,0x34,... -> 8 strobes; first o_wr_data=0x1234; o_row_count=2; o_pixel_count=4; one o_frame_done.
REQ-024 Full: i_wr_full=1 during pixel 3 of row 0 -> 7 strobes, o_overflow=1; o_overflow clears at the next vsync falling edge.
REQ-025 Odd line: href high for 9 bytes -> 4 strobes and o_pixel_count=4.
REQ-026 Mid-frame disable: i_enable=0 after 5 pixels -> o_busy=0 within 1 clk; no o_frame_done; o_row_count holds.
REQ-027 Async reset: rst=0 mid-CAPTURE -> all outputs 0 without waiting for a clk edge; after release, capture waits for the next vsync falling edge.
REQ-028 With SF_CAMERA_TEST_PATTERN_EN defined: a 2x2 frame -> o_wr_data sequence 0x0000, 0x0100, 0x0001, 0x0101.

Source files
------------

// File: rtl/sf_camera_reader.sv
// Camera byte-stream reader: synchronizes pclk/vsync/href and packs byte pairs into RGB565 write strobes.
// Optional build macro SF_CAMERA_TEST_PATTERN_EN replaces camera bytes with a {column, row} pattern.
module sf_camera_reader (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_pclk,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic [7:0]  i_pix_data,
  input  logic        i_wr_full,
  output logic [15:0] o_wr_data,
  output logic        o_wr_stb,
  output logic        o_frame_done,
  output logic [15:0] o_row_count,
  output logic [15:0] o_pixel_count,
  output logic        o_overflow,
  output logic        o_busy
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SYNC_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FRAME, S_WAIT_LINE, S_CAPTURE, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_W-1:0] pclk_sync_q, pclk_sync_d;
  logic [SYNC_W-1:0] vsync_sync_q, vsync_sync_d;
  logic [SYNC_W-1:0] href_sync_q, href_sync_d;
  logic [BYTE_W-1:0] data1_q, data1_d, data2_q, data2_d;

  logic [BYTE_W-1:0] hi_byte_q, hi_byte_d;
  logic              have_hi_q, have_hi_d;
  logic [CNT_W-1:0]  row_pix_q, row_pix_d;
  logic [CNT_W-1:0]  row_count_q, row_count_d;
  logic [CNT_W-1:0]  pixel_count_q, pixel_count_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              wr_stb_q, wr_stb_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;

  logic pclk_ev_c, vs_rise_c, vs_fall_c, href_fall_c, href_lvl_c;
  logic [15:0] pix_word_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Stage [1] is the synchronized level, stage [2] the edge-detect reference.
  always_comb begin
    pclk_sync_d  = {pclk_sync_q[1:0], i_pclk};
    vsync_sync_d = {vsync_sync_q[1:0], i_vsync};
    href_sync_d  = {href_sync_q[1:0], i_href};
    data1_d      = i_pix_data;
    data2_d      = data1_q;
    pclk_ev_c    = pclk_sync_q[1] & ~pclk_sync_q[2];
    vs_rise_c    = vsync_sync_q[1] & ~vsync_sync_q[2];
    vs_fall_c    = ~vsync_sync_q[1] & vsync_sync_q[2];
    href_fall_c  = ~href_sync_q[1] & href_sync_q[2];
    href_lvl_c   = href_sync_q[1];
`ifdef SF_CAMERA_TEST_PATTERN_EN
    pix_word_c   = {row_pix_q[7:0], row_count_q[7:0]};
`else
    pix_word_c   = {hi_byte_q, data2_q};
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Disable wins everywhere except DONE, which always finishes its pulse.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (i_enable) state_d = S_WAIT_FRAME;
      S_WAIT_FRAME: if (!i_enable) state_d = S_IDLE;
                    else if (vs_fall_c) state_d = S_WAIT_LINE;
      S_WAIT_LINE:  if (!i_enable) state_d = S_IDLE;
                    else if (vs_rise_c) state_d = S_DONE;
                    else if (pclk_ev_c && href_lvl_c) state_d = S_CAPTURE;
      S_CAPTURE:    if (!i_enable) state_d = S_IDLE;
                    else if (vs_rise_c) state_d = S_DONE;
                    else if (href_fall_c) state_d = S_WAIT_LINE;
      S_DONE:       state_d = i_enable ? S_WAIT_FRAME : S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hi_byte_d     = hi_byte_q;
    have_hi_d     = have_hi_q;
    row_pix_d     = row_pix_q;
    row_count_d   = row_count_q;
    pixel_count_d = pixel_count_q;
    overflow_d    = overflow_q;
    wr_data_d     = wr_data_q;
    wr_stb_d      = 1'b0;
    frame_done_d  = 1'b0;
    busy_d        = (state_d != S_IDLE);

    case (state_q)
      S_WAIT_FRAME: begin
        if (i_enable && vs_fall_c) begin
          row_count_d   = '0;
          pixel_count_d = '0;
          overflow_d    = 1'b0;
          row_pix_d     = '0;
          have_hi_d     = 1'b0;
        end
      end
      S_WAIT_LINE: begin
        if (i_enable) begin
          if (vs_rise_c) begin
            frame_done_d = 1'b1;
          end else if (pclk_ev_c && href_lvl_c) begin
            hi_byte_d = data2_q;
            have_hi_d = 1'b1;
          end
        end
      end
      S_CAPTURE: begin
        if (i_enable) begin
          // Row close (href fall or partial row at vsync) also drops an odd trailing byte.
          if (href_fall_c || vs_rise_c) begin
            row_count_d   = sat_inc(row_count_q);
            pixel_count_d = row_pix_q;
            row_pix_d     = '0;
            have_hi_d     = 1'b0;
            frame_done_d  = vs_rise_c;
          end else if (pclk_ev_c && href_lvl_c) begin
            if (!have_hi_q) begin
              hi_byte_d = data2_q;
              have_hi_d = 1'b1;
            end else begin
              have_hi_d = 1'b0;
              row_pix_d = sat_inc(row_pix_q);
              if (i_wr_full) begin
                overflow_d = 1'b1;
              end else begin
                wr_stb_d  = 1'b1;
                wr_data_d = pix_word_c;
              end
            end
          end
        end
      end
      default: ;
    endcase

    if (!i_enable && state_q != S_DONE) have_hi_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pclk_sync_q   <= '0;
      vsync_sync_q  <= '0;
      href_sync_q   <= '0;
      data1_q       <= '0;
      data2_q       <= '0;
      hi_byte_q     <= '0;
      have_hi_q     <= 1'b0;
      row_pix_q     <= '0;
      row_count_q   <= '0;
      pixel_count_q <= '0;
      overflow_q    <= 1'b0;
      wr_data_q     <= '0;
      wr_stb_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      pclk_sync_q   <= pclk_sync_d;
      vsync_sync_q  <= vsync_sync_d;
      href_sync_q   <= href_sync_d;
      data1_q       <= data1_d;
      data2_q       <= data2_d;
      hi_byte_q     <= hi_byte_d;
      have_hi_q     <= have_hi_d;
      row_pix_q     <= row_pix_d;
      row_count_q   <= row_count_d;
      pixel_count_q <= pixel_count_d;
      overflow_q    <= overflow_d;
      wr_data_q     <= wr_data_d;
      wr_stb_q      <= wr_stb_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
    end
  end

  assign o_wr_data     = wr_data_q;
  assign o_wr_stb      = wr_stb_q;
  assign o_frame_done  = frame_done_q;
  assign o_row_count   = row_count_q;
  assign o_pixel_count = pixel_count_q;
  assign o_overflow    = overflow_q;
  assign o_busy        = busy_q;

endmodule
